// File: rtl/cordic_sequencer_pkg.sv
// Shared constants for the CORDIC iteration sequencer: mode codes, defaults, FSM codes,
// hyperbolic repeat indices and the Q2.30 elementary-angle tables.
package cordic_sequencer_pkg;

    localparam logic [1:0] MODE_CIRCULAR   = 2'b00;
    localparam logic [1:0] MODE_LINEAR     = 2'b01;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'b10;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_ITER  = 16;
    localparam int unsigned DEFAULT_IDX_W = 5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ITERATE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Hyperbolic CORDIC only converges if these indices are executed twice.
    localparam int unsigned HYP_REPEAT_A = 4;
    localparam int unsigned HYP_REPEAT_B = 13;

    // atan(2^-i) in Q2.30, rounded to nearest.
    function automatic logic [31:0] atan_entry(input int unsigned idx);
        case (idx)
            0:       return 32'h3243_F6A9;
            1:       return 32'h1DAC_6705;
            2:       return 32'h0FAD_BAFD;
            3:       return 32'h07F5_6EA7;
            4:       return 32'h03FE_AB77;
            5:       return 32'h01FF_D55C;
            6:       return 32'h00FF_FAAB;
            7:       return 32'h007F_FF55;
            8:       return 32'h003F_FFEB;
            9:       return 32'h001F_FFFD;
            10:      return 32'h0010_0000;
            11:      return 32'h0008_0000;
            12:      return 32'h0004_0000;
            13:      return 32'h0002_0000;
            14:      return 32'h0001_0000;
            15:      return 32'h0000_8000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // atanh(2^-i) in Q2.30, rounded to nearest; index 0 is never used.
    function automatic logic [31:0] atanh_entry(input int unsigned idx);
        case (idx)
            1:       return 32'h2327_D4F5;
            2:       return 32'h1058_AEFB;
            3:       return 32'h080A_C48E;
            4:       return 32'h0401_5623;
            5:       return 32'h0200_2AB1;
            6:       return 32'h0100_0555;
            7:       return 32'h0080_00AB;
            8:       return 32'h0040_0015;
            9:       return 32'h0020_0003;
            10:      return 32'h0010_0000;
            11:      return 32'h0008_0000;
            12:      return 32'h0004_0000;
            13:      return 32'h0002_0000;
            14:      return 32'h0001_0000;
            15:      return 32'h0000_8000;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/cordic_sequencer_alpha_lut.sv
// Combinational elementary-angle ROM indexed by (mode, iteration index).
module cordic_alpha_lut
    import cordic_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] iter_idx,
    output logic [WIDTH-1:0] alpha
);

    logic [31:0] entry;

    always_comb begin
        entry = '0;
        case (mode)
            MODE_CIRCULAR:   entry = atan_entry(int'(iter_idx));
            MODE_HYPERBOLIC: entry = atanh_entry(int'(iter_idx));
            default:         entry = 32'h4000_0000 >> iter_idx;
        endcase
        alpha = WIDTH'(entry);
    end

endmodule

// File: rtl/cordic_sequencer.sv
// Rotation-CORDIC iteration sequencer: latches a start vector, feeds the per-iteration
// calculators, captures their results and pulses done with the final vector.
module cordic_sequencer
    import cordic_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ITER  = DEFAULT_ITER,
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    input  logic [1:0]       mode_in,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] angle,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] x_shift,
    output logic [WIDTH-1:0] y_shift,
    output logic [WIDTH-1:0] alpha,
    output logic [IDX_W-1:0] iter_idx,
    input  logic [WIDTH-1:0] x_next,
    input  logic [WIDTH-1:0] y_next,
    input  logic [WIDTH-1:0] z_next,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_result,
    output logic [WIDTH-1:0] y_result,
    output logic [WIDTH-1:0] z_result
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);
    localparam logic [IDX_W-1:0] REP_A    = IDX_W'(HYP_REPEAT_A);
    localparam logic [IDX_W-1:0] REP_B    = IDX_W'(HYP_REPEAT_B);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rep_q, rep_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;

    logic             iterating;
    logic             hold_idx;
    logic             last_step;
    logic [1:0]       mode_norm;
    logic [WIDTH-1:0] lut_alpha;
    logic signed [WIDTH-1:0] x_sra, y_sra;

    assign iterating = (state_q == ST_ITERATE);
    assign hold_idx  = (mode_q == MODE_HYPERBOLIC) && !rep_q &&
                       ((idx_q == REP_A) || (idx_q == REP_B));
    // The final step is at the top index once any pending repeat has been taken.
    assign last_step = (idx_q == LAST_IDX) && !hold_idx;
    assign mode_norm = (mode_in == MODE_CIRCULAR || mode_in == MODE_HYPERBOLIC) ?
                       mode_in : MODE_LINEAR;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        busy_d  = busy_q;
        done_d  = done_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = z_in;
                    mode_d  = mode_norm;
                    idx_d   = (mode_norm == MODE_HYPERBOLIC) ? IDX_W'(1) : '0;
                    rep_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_ITERATE;
                end
            end
            ST_ITERATE: begin
                x_d = x_next;
                y_d = y_next;
                z_d = z_next;
                if (last_step) begin
                    xr_d    = x_next;
                    yr_d    = y_next;
                    zr_d    = z_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (hold_idx) begin
                    rep_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    rep_d = 1'b0;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
        end
    end

    cordic_alpha_lut #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_alpha_lut (
        .mode     (mode_q),
        .iter_idx (idx_q),
        .alpha    (lut_alpha)
    );

    // Kept in separate signed nets so the shift stays arithmetic.
    assign x_sra = $signed(x_q) >>> idx_q;
    assign y_sra = $signed(y_q) >>> idx_q;

    assign x_shift  = iterating ? x_sra : '0;
    assign y_shift  = iterating ? y_sra : '0;
    assign alpha    = iterating ? lut_alpha : '0;
    assign x        = x_q;
    assign y        = y_q;
    assign angle    = z_q;
    assign mode     = mode_q;
    assign iter_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign x_result = xr_q;
    assign y_result = yr_q;
    assign z_result = zr_q;

endmodule
